config_source_arbiter: RTL and testbench

Arbitrates fabric configuration words between two serial front-ends: the bitbang receiver and the UART configuration receiver. Each source produces one-cycle strobes with 32-bit words and an active level, and neither source can be back-pressured. The block grants the downstream configuration port to one source per session and buffers that source's words in a 2-entry FIFO. It then presents them on a valid/ready interface to the frame-write logic, flagging dropped words.

---
 rtl/config_source_arbiter_if.sv | 38 +++
 rtl/config_source_arbiter.sv | 149 ++++++++++++++
 tb/tb_config_source_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/config_source_arbiter_if.sv
// Bundles the two source strobe channels and the downstream cfg valid/ready port.
// The word_count signal exists only when CFG_ARB_WORD_COUNT_EN is defined.
interface config_source_arbiter_if;
    logic        bb_strobe;
    logic [31:0] bb_data;
    logic        bb_active;
    logic        uart_strobe;
    logic [31:0] uart_data;
    logic        uart_active;
    logic        cfg_valid;
    logic [31:0] cfg_data;
    logic        cfg_ready;
    logic        cfg_source;
    logic        cfg_busy;
    logic        overrun_err;
    logic        collision_err;
`ifdef CFG_ARB_WORD_COUNT_EN
    logic [15:0] word_count;

    modport master (
        output bb_strobe, bb_data, bb_active, uart_strobe, uart_data, uart_active, cfg_ready,
        input  cfg_valid, cfg_data, cfg_source, cfg_busy, overrun_err, collision_err, word_count
    );
    modport slave (
        input  bb_strobe, bb_data, bb_active, uart_strobe, uart_data, uart_active, cfg_ready,
        output cfg_valid, cfg_data, cfg_source, cfg_busy, overrun_err, collision_err, word_count
    );
`else
    modport master (
        output bb_strobe, bb_data, bb_active, uart_strobe, uart_data, uart_active, cfg_ready,
        input  cfg_valid, cfg_data, cfg_source, cfg_busy, overrun_err, collision_err
    );
    modport slave (
        input  bb_strobe, bb_data, bb_active, uart_strobe, uart_data, uart_active, cfg_ready,
        output cfg_valid, cfg_data, cfg_source, cfg_busy, overrun_err, collision_err
    );
`endif
endinterface

// File: rtl/config_source_arbiter.sv
// Grants the cfg port to the bitbang or UART front-end per session and buffers its words in a 2-deep FIFO.
// Optional CFG_ARB_WORD_COUNT_EN adds a 16-bit per-session transfer counter (word_count).
module config_source_arbiter (
    input  logic                    clk,
    input  logic                    reset,
    config_source_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN_BB, OWN_UART, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] head_q, head_d;
    logic [31:0] tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        source_q, source_d;
    logic        granted_q, granted_d;
    logic        overrun_q, overrun_d;
    logic        collision_q, collision_d;

    logic        grant;
    logic        own_strobe;
    logic        other_strobe;
    logic [31:0] own_data;
    logic        pop;
    logic        push;

    always_comb begin
        state_d      = state_q;
        source_d     = source_q;
        granted_d    = granted_q;
        grant        = 1'b0;
        own_strobe   = 1'b0;
        other_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the source not granted last wins; bitbang wins before any grant.
                if (bus.bb_active && bus.uart_active) begin
                    grant    = 1'b1;
                    source_d = granted_q ? ~source_q : 1'b0;
                end else if (bus.bb_active) begin
                    grant    = 1'b1;
                    source_d = 1'b0;
                end else if (bus.uart_active) begin
                    grant    = 1'b1;
                    source_d = 1'b1;
                end
                if (grant) begin
                    state_d      = source_d ? OWN_UART : OWN_BB;
                    granted_d    = 1'b1;
                    own_strobe   = source_d ? bus.uart_strobe : bus.bb_strobe;
                    other_strobe = source_d ? bus.bb_strobe : bus.uart_strobe;
                end else begin
                    other_strobe = bus.bb_strobe | bus.uart_strobe;
                end
            end
            OWN_BB: begin
                own_strobe   = bus.bb_strobe;
                other_strobe = bus.uart_strobe;
                if (!bus.bb_active) state_d = DRAIN;
            end
            OWN_UART: begin
                own_strobe   = bus.uart_strobe;
                other_strobe = bus.bb_strobe;
                if (!bus.uart_active) state_d = DRAIN;
            end
            default: begin
                other_strobe = source_q ? bus.bb_strobe : bus.uart_strobe;
                if (count_q == 2'd0) state_d = IDLE;
            end
        endcase
        own_data = source_d ? bus.uart_data : bus.bb_data;
    end

    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign pop  = (count_q != 2'd0) && bus.cfg_ready;
    assign push = own_strobe && ((count_q != 2'd2) || pop);

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        overrun_d   = overrun_q | (own_strobe & ~push);
        collision_d = collision_q | other_strobe;
        if (count_q == 2'd0) begin
            if (push) begin
                head_d  = own_data;
                count_d = 2'd1;
            end
        end else if (count_q == 2'd1) begin
            if (push && pop) begin
                head_d = own_data;
            end else if (push) begin
                tail_d  = own_data;
                count_d = 2'd2;
            end else if (pop) begin
                count_d = 2'd0;
            end
        end else if (pop) begin
            head_d = tail_q;
            if (push) tail_d = own_data;
            else      count_d = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            source_q    <= 1'b0;
            granted_q   <= 1'b0;
            overrun_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            source_q    <= source_d;
            granted_q   <= granted_d;
            overrun_q   <= overrun_d;
            collision_q <= collision_d;
        end
    end

`ifdef CFG_ARB_WORD_COUNT_EN
    logic [15:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q;
        if (grant)    word_count_d = 16'd0;
        else if (pop) word_count_d = word_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) word_count_q <= '0;
        else       word_count_q <= word_count_d;
    end

    assign bus.word_count = word_count_q;
`endif

    assign bus.cfg_valid     = (count_q != 2'd0);
    assign bus.cfg_data      = head_q;
    assign bus.cfg_source    = source_q;
    assign bus.cfg_busy      = (state_q != IDLE);
    assign bus.overrun_err   = overrun_q;
    assign bus.collision_err = collision_q;
endmodule

// File: tb/tb_config_source_arbiter.sv
// Scoreboard bench for config_source_arbiter: directed session scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_config_source_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    config_source_arbiter_if bus();
    config_source_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: session phase 0 idle, 1 owning, 2 draining; FIFO occupancy plus word queue.
    int          m_phase;
    int          m_owner;
    int          m_any;
    int          m_cnt;
    bit          m_ovr;
    bit          m_col;
    logic [15:0] m_wc;
    logic [31:0] exp_q[$];

    bit ba_r, ua_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_any = 0; m_cnt = 0;
        m_ovr = 0; m_col = 0; m_wc = 0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        bus.bb_strobe = 0; bus.bb_data = 0; bus.bb_active = 0;
        bus.uart_strobe = 0; bus.uart_data = 0; bus.uart_active = 0;
        bus.cfg_ready = 0;
    endtask

    // Applies one cycle of inputs, predicts the outcome, then checks status just after the edge.
    task automatic step(input bit bs, input logic [31:0] bd, input bit ba,
                        input bit us, input logic [31:0] ud, input bit ua, input bit rdy);
        bit pop, own_s;
        int g;
        bus.bb_strobe = bs; bus.bb_data = bd; bus.bb_active = ba;
        bus.uart_strobe = us; bus.uart_data = ud; bus.uart_active = ua;
        bus.cfg_ready = rdy;
        pop = (m_cnt > 0) && rdy;
        own_s = 0;
        case (m_phase)
            0: begin
                g = -1;
                if (ba && ua) g = m_any ? 1 - m_owner : 0;
                else if (ba)  g = 0;
                else if (ua)  g = 1;
                if (g >= 0) begin
                    m_phase = 1; m_owner = g; m_any = 1; m_wc = 0;
                end
                if (g == 0)      begin own_s = bs; if (us) m_col = 1; end
                else if (g == 1) begin own_s = us; if (bs) m_col = 1; end
                else if (bs || us) m_col = 1;
            end
            1: begin
                own_s = (m_owner == 1) ? us : bs;
                if ((m_owner == 1) ? bs : us) m_col = 1;
                if (!((m_owner == 1) ? ua : ba)) m_phase = 2;
            end
            default: begin
                if ((m_owner == 1) ? bs : us) m_col = 1;
                if (m_cnt == 0) m_phase = 0;
            end
        endcase
        if (own_s) begin
            if (m_cnt < 2 || pop) begin
                exp_q.push_back((m_owner == 1) ? ud : bd);
                m_cnt++;
            end else begin
                m_ovr = 1;
            end
        end
        if (pop) begin
            m_cnt--;
            m_wc = m_wc + 16'd1;
        end
        @(posedge clk);
        #1;
        chk1("cfg_valid", bus.cfg_valid, m_cnt > 0);
        chk1("cfg_busy", bus.cfg_busy, m_phase != 0);
        chk1("cfg_source", bus.cfg_source, m_owner[0]);
        chk1("overrun_err", bus.overrun_err, m_ovr);
        chk1("collision_err", bus.collision_err, m_col);
`ifdef CFG_ARB_WORD_COUNT_EN
        chk("word_count", {16'd0, bus.word_count}, {16'd0, m_wc});
`endif
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk1("rst_cfg_valid", bus.cfg_valid, 1'b0);
        chk1("rst_cfg_busy", bus.cfg_busy, 1'b0);
        chk1("rst_cfg_source", bus.cfg_source, 1'b0);
        chk1("rst_overrun_err", bus.overrun_err, 1'b0);
        chk1("rst_collision_err", bus.collision_err, 1'b0);
        chk("rst_cfg_data", bus.cfg_data, 32'h0);
`ifdef CFG_ARB_WORD_COUNT_EN
        chk("rst_word_count", {16'd0, bus.word_count}, 32'h0);
`endif
        model_reset();
        drive_idle();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic idle_until_done(input int limit);
        for (int i = 0; i < limit && m_phase != 0; i++) step(0, 0, 0, 0, 0, 0, 1);
        chk1("session_end_timeout", m_phase != 0, 1'b0);
    endtask

    // Monitor: the head must match the oldest expected word whenever valid; a transfer retires it.
    initial begin
        logic [31:0] head;
        forever begin
            @(negedge clk);
            if (!reset && bus.cfg_valid) begin
                if (exp_q.size() == 0) begin
                    chk1("unexpected_cfg_valid", bus.cfg_valid, 1'b0);
                end else begin
                    head = exp_q[0];
                    chk("cfg_data", bus.cfg_data, head);
                    if (bus.cfg_ready) head = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        drive_idle();
        model_reset();
        #2;
        do_reset();

        // Bitbang session, one word per cycle drained immediately.
        step(1, 32'h11111111, 1, 0, 0, 0, 1);
        step(1, 32'h22222222, 1, 0, 0, 0, 1);
        step(1, 32'h33333333, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle_until_done(8);

        // Tie after reset goes to bitbang; the next tie goes to UART.
        do_reset();
        step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle_until_done(8);
        step(0, 0, 1, 0, 0, 1, 1);
        // Stalled UART stream: C overruns, a bitbang strobe collides.
        step(0, 0, 1, 1, 32'hAAAA0001, 1, 0);
        step(0, 0, 1, 1, 32'hBBBB0002, 1, 0);
        step(0, 0, 1, 1, 32'hCCCC0003, 1, 0);
        step(1, 32'hDEADBEEF, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle_until_done(8);

        // Full FIFO with simultaneous pop and push, then reset mid-stream.
        do_reset();
        step(0, 0, 0, 1, 32'h0D0D0D0D, 1, 0);
        step(0, 0, 0, 1, 32'h0E0E0E0E, 1, 0);
        step(0, 0, 0, 1, 32'h0F0F0F0F, 1, 1);
        step(1, 32'h12345678, 1, 1, 32'h10101010, 1, 0);
        step(0, 0, 1, 1, 32'h20202020, 1, 1);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1);

        // Owner strobe on the cycle its active falls is still captured.
        step(1, 32'h44444444, 1, 0, 0, 0, 0);
        step(1, 32'h55555555, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle_until_done(8);

`ifdef CFG_ARB_WORD_COUNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 32'h5000 + i, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle_until_done(8);
        chk("word_count_after_5", {16'd0, bus.word_count}, 32'd5);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("word_count_new_grant", {16'd0, bus.word_count}, 32'd0);
        for (int i = 0; i < 65536; i++) step(0, 0, 0, 1, i, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle_until_done(8);
        chk("word_count_wrap", {16'd0, bus.word_count}, 32'd0);
`endif

        // Random traffic against the model.
        do_reset();
        ba_r = 0; ua_r = 0;
        for (int i = 0; i < 3000; i++) begin
            bit bs, us, rdy;
            if ($urandom_range(0, 9) == 0) ba_r = ~ba_r;
            if ($urandom_range(0, 9) == 0) ua_r = ~ua_r;
            bs = (ba_r || (m_phase == 1 && m_owner == 0)) && !(m_phase == 2 && m_owner == 0)
                 && ($urandom_range(0, 1) == 1);
            us = (ua_r || (m_phase == 1 && m_owner == 1)) && !(m_phase == 2 && m_owner == 1)
                 && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 3) != 0);
            step(bs, $urandom, ba_r, us, $urandom, ua_r, rdy);
        end
        idle_until_done(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
